// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and the step-counter width helper.
package iterative_divider_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StZero = 2'd3
    } div_state_e;

    // Counter must hold WIDTH itself, hence WIDTH+1 distinct values.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, keep the difference only
// when it does not go negative.
module div_step
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction one bit wider than the operands; the top bit is the borrow.
    always_comb begin
        shifted = {rem, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        // rem < divisor on entry, so a failed trial leaves shifted within WIDTH bits.
        new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient -> LO, remainder -> HI.
// One quotient bit per cycle on operand magnitudes, sign fix-up in a final cycle.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q;       // dividend magnitude, becomes quotient bits
    logic [WIDTH-1:0] dvs_q;       // divisor magnitude
    logic [WIDTH-1:0] rem_q;       // partial remainder
    logic [CntW-1:0]  cnt_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             last_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .new_rem (step_rem),
        .q_bit   (step_qbit)
    );

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag = (signed_op && B[WIDTH-1]) ? -B : B;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (B == '0) ? StZero : StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            StZero:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived outputs and result ports.
    always_comb begin
        busy        = (state_q != StIdle);
        last_step   = (cnt_q == CntW'(1));
        quotient    = quotient_q;
        remainder   = remainder_q;
        done        = done_q;
        div_by_zero = dbz_q;
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Zero divisor path keeps the raw dividend for the remainder.
                        dvd_q     <= (B == '0) ? A : a_mag;
                        dvs_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= CntW'(WIDTH);
                        quo_neg_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rem_neg_q <= signed_op & A[WIDTH-1];
                        dbz_q     <= 1'b0;
                    end
                end
                StRun: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_qbit};
                    cnt_q <= cnt_q - 1'b1;
                end
                StFix: begin
                    quotient_q  <= quo_neg_q ? -dvd_q : dvd_q;
                    remainder_q <= rem_neg_q ? -rem_q : rem_q;
                    done_q      <= 1'b1;
                end
                StZero: begin
                    quotient_q  <= '1;
                    remainder_q <= dvd_q;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: the driver pushes model results on
// each accepted start, a negedge monitor pops and compares on every done.
module tb_iterative_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    iterative_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .A           (a_in),
        .B           (b_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dbz;
        int unsigned  done_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int unsigned reset_count;
    bit          checking;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain integer division, truncating toward zero for signed.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t   e;
        longint sa;
        longint sd;
        e.done_cyc = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            sa    = longint'($signed(a));
            sd    = longint'($signed(b));
            e.q   = W'(sa / sd);
            e.r   = W'(sa % sd);
            e.dbz = 1'b0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: all comparisons happen here.
    initial begin
        logic [W-1:0] hold_q;
        logic [W-1:0] hold_r;
        int unsigned  seen_rst;
        exp_t         e;
        hold_q   = '0;
        hold_r   = '0;
        seen_rst = 0;
        forever begin
            @(negedge clk);
            if (checking) begin
                if (reset_count != seen_rst) begin
                    seen_rst = reset_count;
                    hold_q   = '0;
                    hold_r   = '0;
                    check("reset_quotient", quotient, '0);
                    check("reset_remainder", remainder, '0);
                    check("reset_busy", W'(busy), '0);
                    check("reset_done", W'(done), '0);
                    check("reset_div_by_zero", W'(div_by_zero), '0);
                end
                if (done) begin
                    check("busy_in_done", W'(busy), '0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", W'(done), '0);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", quotient, e.q);
                        check("remainder", remainder, e.r);
                        check("div_by_zero", W'(div_by_zero), W'(e.dbz));
                        check("latency_cycle", W'(cyc), W'(e.done_cyc));
                        hold_q = e.q;
                        hold_r = e.r;
                    end
                end else begin
                    check("busy", W'(busy), W'(sb.size() != 0));
                    check("hold_quotient", quotient, hold_q);
                    check("hold_remainder", remainder, hold_r);
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns just after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t e;
        a_in      = a;
        b_in      = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e          = model(a, b, s);
        e.done_cyc = cyc + ((b == '0) ? 1 : W + 1);
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (done) return;
        end
        $display("FAIL wait_done: no done within %0d cycles", W + 10);
        $fatal(1, "done never arrived");
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       input bit b2b);
        if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
        issue(a, b, s);
        wait_done();
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int unsigned  sel;
        n_checks    = 0;
        n_fail      = 0;
        reset_count = 0;
        checking    = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        signed_op   = 1'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (3) @(posedge clk);
        #1;
        reset       = 1'b0;
        reset_count = 1;
        checking    = 1'b1;

        // Directed cases.
        run(32'd100, 32'd7, 1'b0, 1'b0);
        run(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run(32'hE43C_E883, 32'hC0E3_5A32, 1'b0, 1'b0);
        run(32'd5, 32'd0, 1'b0, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Start while busy with new operands is ignored.
        @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        a_in  = 32'd7;
        b_in  = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'd17, 1'b1);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        reset_count++;
        repeat (W + 5) @(negedge clk);
        run(32'd12345, 32'd10, 1'b0, 1'b1);

        // Randomized operations, some started in the done cycle.
        for (int i = 0; i < 60; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = '1;
                3: begin
                    ra = 32'h8000_0000;
                    rb = $urandom;
                end
                default: rb = $urandom;
            endcase
            run(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
